box_motion_ctrl: RTL and testbench
==================================

Name: box_motion_ctrl

Overview:
- Frame-rate controller that positions the on-screen box drawn by the box renderer.
- Once per frame, during vertical blanking, it computes the next box origin and commits it to registered `box_x`/`box_y` outputs. The box renderer takes these as its X/Y start in place of fixed constants.
- Two modes: auto-bounce (box reflects off screen edges) and manual (directional button requests).
- Commits occur only while the renderer is not drawing, so there is no tearing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BOX_WIDTH, 100, box width in pixels
- BOX_HEIGHT, 100, box height in lines
- INIT_X, 200, box_x after reset
- INIT_Y, 150, box_y after reset

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse at start of vertical blanking
- auto_en  in  1  1 = auto-bounce mode, 0 = manual mode
- btn_up  in  1  manual request, decrease y (already synchronised level)
- btn_down  in  1  manual request, increase y
- btn_left  in  1  manual request, decrease x
- btn_right  in  1  manual request, increase x
- speed  in  4  step size in pixels per frame; 0 = frozen
- box_x  out  10  committed box X origin
- box_y  out  10  committed box Y origin
- update_done  out  1  single-cycle pulse when a new position is committed
- overrun  out  1  sticky: frame_start arrived while an update was in progress

Behaviour:
- Reset (asynchronous, rst_n low):
  - box_x=INIT_X, box_y=INIT_Y, update_done=0, overrun=0.
  - dir_x=+, dir_y=+, FSM=IDLE.
  - Effect is immediate, including mid-update; any partial computation is discarded.
- Limits: X_MAX = H_ACTIVE-BOX_WIDTH (540), Y_MAX = V_ACTIVE-BOX_HEIGHT (380).
- FSM states: IDLE, CALC_X, CALC_Y, COMMIT.
  - IDLE: frame_start=1 at edge N snapshots auto_en, buttons and speed, and moves to CALC_X.
  - CALC_X (edge N+1): computes nx and next dir_x, then moves to CALC_Y.
  - CALC_Y (edge N+2): computes ny and next dir_y, then moves to COMMIT.
  - COMMIT (edge N+3): box_x<=nx, box_y<=ny, direction registers updated, update_done=1 for exactly that cycle, returns to IDLE.
  - Fixed latency: 3 clocks from frame_start sample to the output change.
- Inputs changing after the snapshot have no effect until the next frame. A mode change takes effect at the next frame_start.
- Arithmetic uses 11-bit intermediates; no wrap-around is permitted.
- Auto mode, per axis (X shown, Y identical with Y_MAX):
  - dir + and x+speed >= X_MAX: nx=X_MAX, dir flips to −.
  - dir + otherwise: nx=x+speed.
  - dir − and x <= speed: nx=0, dir flips to +.
  - dir − otherwise: nx=x−speed.
  - speed=0: position and direction unchanged.
- Manual mode:
  - btn_right alone: nx=min(x+speed, X_MAX).
  - btn_left alone: nx=max(x−speed, 0).
  - Both or neither pressed: nx=x.
  - Y axis behaves the same using btn_down/btn_up.
  - Direction registers hold their values in manual mode.
- frame_start while FSM≠IDLE: the pulse is ignored and overrun is set to 1. overrun stays 1 until reset.
- frame_start in the same cycle as COMMIT: ignored and counts as overrun. A frame is never queued.
- Outputs stay constant except at COMMIT and reset.
- A position already beyond its limit (reachable only through a parameter misconfiguration) is clamped to the limit at the next update.

Test Plan:
- Reset, auto_en=1, speed=4, frame_start at cycle 10 → box_x/box_y stay 200/150 through cycle 12; at edge 13 they become 204/154; update_done high for cycle 13 only.
- Auto mode, box_x=538, dir_x=+, speed=4, one frame → box_x=540, dir flips. Next frame → 536.
- Auto mode, box_y=2, dir_y=−, speed=5 → box_y=0, dir flips. Next frame → 5.
- Manual mode, box_x=1, speed=3, btn_left → 0. Repeat → stays 0. Then btn_left+btn_right+btn_up with box_y=150 → box_x=0, box_y=147.
- Manual mode, speed=0, all buttons pressed → no movement; update_done still pulses; dir_x/dir_y unchanged on return to auto.
- frame_start at cycles 10 and 11 → one update at edge 13, overrun=1. rst_n low at cycle 12 of a new update → outputs 200/150 immediately, overrun=0, no update_done.

Source files
------------

// File: rtl/box_motion_ctrl.sv
// Frame-rate box position controller: once per frame (during vblank) computes the
// next box origin in auto-bounce or manual mode and commits it 3 clocks after frame_start.
module box_motion_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BOX_WIDTH  = 100,
  parameter int BOX_HEIGHT = 100,
  parameter int INIT_X     = 200,
  parameter int INIT_Y     = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       auto_en,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [3:0] speed,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       update_done,
  output logic       overrun
);

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_WIDTH);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BOX_HEIGHT);

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_e;

  // dir: 1 = moving toward larger coordinates
  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
  } axis_t;

  // One axis step; every result is clamped to [0, lim] so a misconfigured
  // out-of-range position is pulled back on the next update.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic [10:0] lim,
                                      input logic [3:0] spd, input logic auto,
                                      input logic dir, input logic inc, input logic dec);
    logic [10:0] p, s, sum, dif;
    axis_t r;
    p   = {1'b0, pos};
    s   = {7'b0, spd};
    sum = p + s;
    dif = p - s;
    r.dir = dir;
    r.pos = (p > lim) ? lim[9:0] : pos;
    if (auto) begin
      if (spd != 4'd0) begin
        if (dir) begin
          if (sum >= lim) begin
            r.pos = lim[9:0];
            r.dir = 1'b0;
          end else begin
            r.pos = sum[9:0];
          end
        end else if (p <= s) begin
          r.pos = 10'd0;
          r.dir = 1'b1;
        end else begin
          r.pos = (dif > lim) ? lim[9:0] : dif[9:0];
        end
      end
    end else if (inc && !dec) begin
      r.pos = (sum > lim) ? lim[9:0] : sum[9:0];
    end else if (dec && !inc) begin
      r.pos = (p <= s) ? 10'd0 : ((dif > lim) ? lim[9:0] : dif[9:0]);
    end
    return r;
  endfunction

  state_e     state_q, state_d;
  logic       auto_q, auto_d;
  logic [3:0] btn_q, btn_d;     // {up, down, left, right}
  logic [3:0] spd_q, spd_d;
  axis_t      nx_q, nx_d, ny_q, ny_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [9:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic       update_done_q, update_done_d;
  logic       overrun_q, overrun_d;

  always_comb begin
    state_d       = state_q;
    auto_d        = auto_q;
    btn_d         = btn_q;
    spd_d         = spd_q;
    nx_d          = nx_q;
    ny_d          = ny_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    box_x_d       = box_x_q;
    box_y_d       = box_y_q;
    update_done_d = 1'b0;
    overrun_d     = overrun_q;

    // A pulse outside IDLE is dropped, never queued.
    if (frame_start && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: if (frame_start) begin
        auto_d  = auto_en;
        btn_d   = {btn_up, btn_down, btn_left, btn_right};
        spd_d   = speed;
        state_d = CALC_X;
      end
      CALC_X: begin
        nx_d    = axis_step(box_x_q, X_MAX, spd_q, auto_q, dir_x_q, btn_q[0], btn_q[1]);
        state_d = CALC_Y;
      end
      CALC_Y: begin
        ny_d    = axis_step(box_y_q, Y_MAX, spd_q, auto_q, dir_y_q, btn_q[2], btn_q[3]);
        state_d = COMMIT;
      end
      COMMIT: begin
        box_x_d       = nx_q.pos;
        box_y_d       = ny_q.pos;
        dir_x_d       = nx_q.dir;
        dir_y_d       = ny_q.dir;
        update_done_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      auto_q        <= 1'b0;
      btn_q         <= '0;
      spd_q         <= '0;
      nx_q          <= '0;
      ny_q          <= '0;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      box_x_q       <= 10'(INIT_X);
      box_y_q       <= 10'(INIT_Y);
      update_done_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      auto_q        <= auto_d;
      btn_q         <= btn_d;
      spd_q         <= spd_d;
      nx_q          <= nx_d;
      ny_q          <= ny_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      box_x_q       <= box_x_d;
      box_y_q       <= box_y_d;
      update_done_q <= update_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign box_x       = box_x_q;
  assign box_y       = box_y_q;
  assign update_done = update_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Bench for box_motion_ctrl: vector table, directed corner sequences and random
// frames checked against an arithmetic reference model of the motion rules.
module tb_box_motion_ctrl;

  localparam int X_MAX = 540;
  localparam int Y_MAX = 380;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       auto_en = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0] speed = '0;
  logic [9:0] box_x, box_y;
  logic       update_done, overrun;

  box_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .auto_en(auto_en),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .speed(speed), .box_x(box_x), .box_y(box_y),
    .update_done(update_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mx, my, mdx, mdy;   // model position and direction (+1 / -1)
  int exp_ovr = 0;

  typedef struct {
    bit a, u, dn, l, r;
    int spd;
    int ex, ey;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic void model_reset();
    mx = 200; my = 150; mdx = 1; mdy = 1;
  endfunction

  // Motion rules for one axis with plain integer arithmetic.
  function automatic void model_axis(inout int p, inout int d, input int lim,
                                     input bit a, input bit inc, input bit dec, input int s);
    if (a) begin
      if (s == 0) p = p;
      else if (d > 0) begin
        if (p + s >= lim) begin p = lim; d = -1; end
        else p = p + s;
      end else begin
        if (p <= s) begin p = 0; d = 1; end
        else p = p - s;
      end
    end else if (inc && !dec) p = (p + s > lim) ? lim : p + s;
    else if (dec && !inc) p = (p - s < 0) ? 0 : p - s;
    if (p > lim) p = lim;
  endfunction

  // One frame: pulse frame_start, scramble inputs after the snapshot, wait for update_done.
  task automatic do_frame(input bit a, input bit u, input bit dn, input bit l, input bit r,
                          input int spd, input bit exact);
    bit seen;
    int ox, oy;
    ox = mx; oy = my; seen = 0;
    @(negedge clk);
    auto_en = a; btn_up = u; btn_down = dn; btn_left = l; btn_right = r;
    speed = 4'(spd); frame_start = 1'b1;
    model_axis(mx, mdx, X_MAX, a, r, l, spd);
    model_axis(my, mdy, Y_MAX, a, dn, u, spd);
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        frame_start = 1'b0;
        auto_en = 1'($urandom); btn_up = 1'($urandom); btn_down = 1'($urandom);
        btn_left = 1'($urandom); btn_right = 1'($urandom); speed = 4'($urandom);
      end
      if (update_done) begin
        seen = 1;
        if (exact) check("latency", k, 4);
      end else if (exact && k < 4) begin
        check("hold_x", box_x, ox);
        check("hold_y", box_y, oy);
      end
    end
    check("update_seen", seen, 1);
    check("box_x", box_x, mx);
    check("box_y", box_y, my);
    check("overrun", overrun, exp_ovr);
    if (exact) begin
      @(negedge clk);
      check("ud_single", update_done, 0);
    end
  endtask

  initial begin
    int cnt;
    tbl[0] = '{1, 0, 0, 0, 0,  4, 204, 154};
    tbl[1] = '{0, 0, 0, 0, 1, 15, 219, 154};
    tbl[2] = '{0, 1, 1, 1, 0, 10, 209, 154};
    tbl[3] = '{0, 0, 1, 0, 0,  0, 209, 154};
    tbl[4] = '{1, 0, 0, 0, 0,  1, 210, 155};
    tbl[5] = '{0, 1, 0, 0, 0, 15, 210, 140};

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_x", box_x, 200);
    check("rst_y", box_y, 150);
    check("rst_ud", update_done, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    foreach (tbl[i]) begin
      do_frame(tbl[i].a, tbl[i].u, tbl[i].dn, tbl[i].l, tbl[i].r, tbl[i].spd, i == 0);
      check($sformatf("tbl%0d_x", i), box_x, tbl[i].ex);
      check($sformatf("tbl%0d_y", i), box_y, tbl[i].ey);
      repeat (2) @(negedge clk);
    end

    // Right-edge bounce.
    repeat (25) do_frame(0, 0, 0, 0, 1, 15, 0);
    do_frame(0, 0, 0, 1, 0, 2, 0);
    check("x538", box_x, 538);
    do_frame(1, 0, 0, 0, 0, 4, 1);
    check("x540", box_x, 540);
    do_frame(1, 0, 0, 0, 0, 4, 0);
    check("x536", box_x, 536);

    // Bottom bounce flips dir_y, then top bounce from y=2.
    repeat (20) do_frame(0, 0, 1, 0, 0, 15, 0);
    do_frame(1, 0, 0, 0, 0, 4, 0);
    check("y380", box_y, 380);
    repeat (30) do_frame(0, 1, 0, 0, 0, 15, 0);
    do_frame(0, 0, 1, 0, 0, 2, 0);
    check("y2", box_y, 2);
    do_frame(1, 0, 0, 0, 0, 5, 0);
    check("y0", box_y, 0);
    do_frame(1, 0, 0, 0, 0, 5, 0);
    check("y5", box_y, 5);

    // Manual clamp at left edge, then conflicting horizontal buttons.
    repeat (40) do_frame(0, 0, 0, 1, 0, 15, 0);
    do_frame(0, 0, 0, 0, 1, 1, 0);
    check("x1", box_x, 1);
    do_frame(0, 0, 0, 1, 0, 3, 0);
    check("x0a", box_x, 0);
    do_frame(0, 0, 0, 1, 0, 3, 0);
    check("x0b", box_x, 0);
    do_frame(0, 1, 0, 1, 1, 3, 0);
    check("x0c", box_x, 0);
    check("y2b", box_y, 2);

    // Frozen manual frame, then auto shows directions kept.
    do_frame(0, 1, 1, 1, 1, 0, 1);
    do_frame(1, 0, 0, 0, 0, 1, 0);

    repeat (150) begin
      do_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 15)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Back-to-back frame_start: one update only, overrun set.
    @(negedge clk);
    auto_en = 1; speed = 4'd3; frame_start = 1'b1;
    model_axis(mx, mdx, X_MAX, 1, 0, 0, 3);
    model_axis(my, mdy, Y_MAX, 1, 0, 0, 3);
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (update_done) cnt++;
    end
    exp_ovr = 1;
    check("ovr_updates", cnt, 1);
    check("ovr_flag", overrun, 1);
    check("ovr_x", box_x, mx);
    check("ovr_y", box_y, my);
    do_frame(0, 0, 1, 0, 1, 7, 0);

    // Reset mid-update discards the computation.
    @(negedge clk);
    auto_en = 1; speed = 4'd9; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_x", box_x, 200);
    check("mid_rst_y", box_y, 150);
    check("mid_rst_ovr", overrun, 0);
    check("mid_rst_ud", update_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (update_done) cnt++;
    end
    check("mid_rst_no_ud", cnt, 0);
    model_reset();
    exp_ovr = 0;
    do_frame(1, 0, 0, 0, 0, 4, 1);
    check("post_rst_x", box_x, 204);
    check("post_rst_y", box_y, 154);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
